// File: rtl/compuertas_pkg.sv
// Shared types and constants for the gate-selector sweep engine.
package compuertas_pkg;

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned ENT_W   = 3;
  localparam int unsigned TABLA_W = 8;

  // Function codes understood by the gate selector.
  localparam logic [SEL_W-1:0] SEL_AND  = 3'd1;
  localparam logic [SEL_W-1:0] SEL_OR   = 3'd2;
  localparam logic [SEL_W-1:0] SEL_NAND = 3'd3;
  localparam logic [SEL_W-1:0] SEL_NOR  = 3'd4;
  localparam logic [SEL_W-1:0] SEL_XOR  = 3'd5;
  localparam logic [SEL_W-1:0] SEL_XNOR = 3'd6;

  // Golden truth tables indexed by sel; bit k is the output for {ent1,ent2,ent3} = k.
  localparam logic [7:0][TABLA_W-1:0] TABLA_ORO = {
    8'h00,  // 7: unused code
    8'h69,  // 6: XNOR3
    8'h96,  // 5: XOR3
    8'h01,  // 4: NOR3
    8'h7F,  // 3: NAND3
    8'hFE,  // 2: OR3
    8'h80,  // 1: AND3
    8'h00   // 0: no function
  };

  typedef enum logic [2:0] {
    REPOSO,
    DESACT,
    BARRIDO,
    REPORTE,
    FIN
  } estado_t;

  function automatic logic [TABLA_W-1:0] tabla_oro(input logic [SEL_W-1:0] sel);
    return TABLA_ORO[sel];
  endfunction

endpackage

// File: rtl/barrido_compuertas_if.sv
// Stimulus/response bus between the sweep engine and the gate selector under test.
interface barrido_compuertas_if;
  import compuertas_pkg::*;

  logic [SEL_W-1:0] sel_o;
  logic             act_o;
  logic             ent1_o;
  logic             ent2_o;
  logic             ent3_o;
  logic             sal_i;

  modport master (output sel_o, act_o, ent1_o, ent2_o, ent3_o, input sal_i);
  modport slave  (input sel_o, act_o, ent1_o, ent2_o, ent3_o, output sal_i);
endinterface

// File: rtl/barrido_compuertas_secuenciador.sv
// Combination counter k with a settle timer that holds each value ESPERA+1 cycles.
module secuenciador_combinaciones
  import compuertas_pkg::*;
#(
  parameter int unsigned ESPERA = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [ENT_W-1:0] ent,
  output logic             muestra_c,
  output logic             ultima_c
);

  localparam int unsigned TW = (ESPERA > 0) ? $clog2(ESPERA + 1) : 1;

  logic [TW-1:0]    t;
  logic [ENT_W-1:0] k;

  assign ent       = k;
  assign muestra_c = (t == TW'(ESPERA));
  assign ultima_c  = (k == 3'd7);

  // Hold timer and k advance; k wraps to 0 after the last combination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t <= '0;
      k <= '0;
    end else if (clr) begin
      t <= '0;
      k <= '0;
    end else if (en) begin
      if (muestra_c) begin
        t <= '0;
        k <= k + 3'd1;
      end else begin
        t <= t + TW'(1);
      end
    end
  end

endmodule

// File: rtl/barrido_compuertas.sv
// Sweep engine: drives every function/combination, captures and checks truth tables.
module barrido_compuertas
  import compuertas_pkg::*;
#(
  parameter int unsigned NUM_FUNC = 6,
  parameter int unsigned ESPERA   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inicio,
  barrido_compuertas_if.master   prueba,
  output logic                   ocupado,
  output logic [TABLA_W-1:0]     tabla_o,
  output logic                   tabla_valida,
  output logic [TABLA_W-1:0]     fallos_o,
  output logic                   listo
);

  estado_t          estado;
  logic [SEL_W-1:0] sel;
  logic             act;
  logic [ENT_W-1:0] ent;
  logic             muestra_c;
  logic             ultima_c;
  logic             en_c;
  logic             clr_c;

  // Timer runs while driving stimulus; it restarts when leaving DESACT and outside sweeping.
  assign en_c  = (estado == DESACT) || (estado == BARRIDO);
  assign clr_c = ((estado == DESACT) && muestra_c) || !en_c;

  secuenciador_combinaciones #(.ESPERA(ESPERA)) u_secuenciador (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_c),
    .clr       (clr_c),
    .ent       (ent),
    .muestra_c (muestra_c),
    .ultima_c  (ultima_c)
  );

  assign prueba.sel_o  = sel;
  assign prueba.act_o  = act;
  assign prueba.ent1_o = ent[2];
  assign prueba.ent2_o = ent[1];
  assign prueba.ent3_o = ent[0];

  // Sweep FSM with capture, golden compare and sticky fault bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado       <= REPOSO;
      sel          <= '0;
      act          <= 1'b0;
      ocupado      <= 1'b0;
      tabla_o      <= '0;
      tabla_valida <= 1'b0;
      fallos_o     <= '0;
      listo        <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (inicio) begin
            fallos_o <= '0;
            tabla_o  <= '0;
            ocupado  <= 1'b1;
            estado   <= DESACT;
          end
        end
        DESACT: begin
          if (muestra_c) begin
            if (prueba.sal_i) fallos_o[0] <= 1'b1;
            sel    <= 3'd1;
            act    <= 1'b1;
            estado <= BARRIDO;
          end
        end
        BARRIDO: begin
          if (muestra_c) begin
            tabla_o[ent] <= prueba.sal_i;
            if (ultima_c) begin
              tabla_valida <= 1'b1;
              estado       <= REPORTE;
            end
          end
        end
        REPORTE: begin
          tabla_valida <= 1'b0;
          if (tabla_o != tabla_oro(sel)) fallos_o[sel] <= 1'b1;
          if (sel == SEL_W'(NUM_FUNC)) begin
            listo  <= 1'b1;
            act    <= 1'b0;
            estado <= FIN;
          end else begin
            sel     <= sel + 3'd1;
            tabla_o <= '0;
            estado  <= BARRIDO;
          end
        end
        FIN: begin
          listo   <= 1'b0;
          ocupado <= 1'b0;
          sel     <= '0;
          estado  <= REPOSO;
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_barrido_compuertas.sv
// Directed bench: gate-selector models under the sweep engine, table-driven table checks.
module tb_barrido_compuertas;
  import compuertas_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inicio_a = 1'b0;
  logic       inicio_b = 1'b0;
  int         modo = 0;

  logic       ocupado_a, tabla_valida_a, listo_a;
  logic [7:0] tabla_a, fallos_a;
  logic       ocupado_b, tabla_valida_b, listo_b;
  logic [7:0] tabla_b, fallos_b;

  int errores = 0;
  int checks  = 0;

  always #5 clk = ~clk;

  barrido_compuertas_if bus_a ();
  barrido_compuertas_if bus_b ();

  barrido_compuertas #(.NUM_FUNC(6), .ESPERA(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .inicio(inicio_a), .prueba(bus_a),
    .ocupado(ocupado_a), .tabla_o(tabla_a), .tabla_valida(tabla_valida_a),
    .fallos_o(fallos_a), .listo(listo_a)
  );

  barrido_compuertas #(.NUM_FUNC(6), .ESPERA(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .inicio(inicio_b), .prueba(bus_b),
    .ocupado(ocupado_b), .tabla_o(tabla_b), .tabla_valida(tabla_valida_b),
    .fallos_o(fallos_b), .listo(listo_b)
  );

  // Behavioural gate selector; m=1 wires XOR as OR.
  function automatic logic puerta(input logic [2:0] s, input logic a, b, c, input int m);
    case (s)
      SEL_AND:  return a & b & c;
      SEL_OR:   return a | b | c;
      SEL_NAND: return ~(a & b & c);
      SEL_NOR:  return ~(a | b | c);
      SEL_XOR:  return (m == 1) ? (a | b | c) : (a ^ b ^ c);
      SEL_XNOR: return ~(a ^ b ^ c);
      default:  return 1'b0;
    endcase
  endfunction

  // Model A has one register stage; m=2 leaks a 1 while disabled.
  always @(posedge clk)
    bus_a.sal_i <= bus_a.act_o ? puerta(bus_a.sel_o, bus_a.ent1_o, bus_a.ent2_o, bus_a.ent3_o, modo)
                               : (modo == 2);

  // Model B is purely combinational and always correct.
  assign bus_b.sal_i = bus_b.act_o ? puerta(bus_b.sel_o, bus_b.ent1_o, bus_b.ent2_o, bus_b.ent3_o, 0)
                                   : 1'b0;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] tabla;
  } vec_t;

  vec_t       vec[6];
  logic [7:0] capt_a[8];
  logic [7:0] capt_b[8];
  int         listo_a_n, listo_a_cnt, listo_b_n, listo_b_cnt;

  task automatic chk(input string nombre, input logic [31:0] real_v, input logic [31:0] esperado);
    checks++;
    if (real_v !== esperado) begin
      errores++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nombre, real_v, esperado);
    end
  endtask

  // One sweep: observe both engines for 130 cycles, optionally poking stray inicio at cycles 10 and 60.
  task automatic barrido(input bit perdidos, input bit con_b);
    for (int i = 0; i < 8; i++) begin
      capt_a[i] = 8'h00;
      capt_b[i] = 8'h00;
    end
    listo_a_n = 0; listo_a_cnt = 0; listo_b_n = 0; listo_b_cnt = 0;
    @(negedge clk);
    inicio_a = 1'b1;
    inicio_b = con_b;
    @(negedge clk);
    inicio_a = 1'b0;
    inicio_b = 1'b0;
    chk("ocupado_arranque", 32'(ocupado_a), 32'd1);
    for (int n = 1; n <= 130; n++) begin
      if (tabla_valida_a) capt_a[bus_a.sel_o] = tabla_a;
      if (tabla_valida_b) capt_b[bus_b.sel_o] = tabla_b;
      if (listo_a) begin listo_a_cnt++; listo_a_n = n; end
      if (listo_b) begin listo_b_cnt++; listo_b_n = n; end
      inicio_a = perdidos && (n == 10 || n == 60);
      @(negedge clk);
    end
    inicio_a = 1'b0;
  endtask

  task automatic verificar(input int modo_v, input logic [7:0] fallos_exp);
    logic [7:0] exp_t;
    for (int i = 0; i < 6; i++) begin
      exp_t = (modo_v == 1 && vec[i].sel == SEL_XOR) ? 8'hFE : vec[i].tabla;
      chk($sformatf("tabla_m%0d_sel%0d", modo_v, vec[i].sel), 32'(capt_a[vec[i].sel]), 32'(exp_t));
    end
    chk($sformatf("fallos_m%0d", modo_v), 32'(fallos_a), 32'(fallos_exp));
    chk($sformatf("listo_cnt_m%0d", modo_v), 32'(listo_a_cnt), 32'd1);
    chk($sformatf("listo_ciclo_m%0d", modo_v), 32'(listo_a_n), 32'd105);
  endtask

  task automatic todo_cero(input string tag);
    chk({tag, "_ocupado"}, 32'(ocupado_a), 0);
    chk({tag, "_sel"}, 32'(bus_a.sel_o), 0);
    chk({tag, "_act"}, 32'(bus_a.act_o), 0);
    chk({tag, "_ent"}, 32'({bus_a.ent1_o, bus_a.ent2_o, bus_a.ent3_o}), 0);
    chk({tag, "_tabla"}, 32'(tabla_a), 0);
    chk({tag, "_valida"}, 32'(tabla_valida_a), 0);
    chk({tag, "_fallos"}, 32'(fallos_a), 0);
    chk({tag, "_listo"}, 32'(listo_a), 0);
  endtask

  initial begin
    vec[0] = '{SEL_AND,  8'h80};
    vec[1] = '{SEL_OR,   8'hFE};
    vec[2] = '{SEL_NAND, 8'h7F};
    vec[3] = '{SEL_NOR,  8'h01};
    vec[4] = '{SEL_XOR,  8'h96};
    vec[5] = '{SEL_XNOR, 8'h69};

    repeat (3) @(negedge clk);
    todo_cero("reset");
    rst_n = 1'b1;

    // Correct model, both settle settings.
    modo = 0;
    barrido(1'b0, 1'b1);
    verificar(0, 8'h00);
    for (int i = 0; i < 6; i++)
      chk($sformatf("tabla_b_sel%0d", vec[i].sel), 32'(capt_b[vec[i].sel]), 32'(vec[i].tabla));
    chk("fallos_b", 32'(fallos_b), 0);
    chk("listo_b_cnt", 32'(listo_b_cnt), 1);
    chk("listo_b_ciclo", 32'(listo_b_n), 56);
    chk("reposo_tabla_retenida", 32'(tabla_a), 32'h69);
    chk("reposo_ocupado", 32'(ocupado_a), 0);
    chk("reposo_sel", 32'(bus_a.sel_o), 0);

    // XOR wired as OR.
    modo = 1;
    barrido(1'b0, 1'b0);
    verificar(1, 8'h20);
    chk("reposo_fallos_retenido", 32'(fallos_a), 32'h20);

    // Stray inicio during sweep; new sweep clears previous faults.
    modo = 0;
    barrido(1'b1, 1'b0);
    verificar(0, 8'h00);

    // Output leaks while disabled.
    modo = 2;
    barrido(1'b0, 1'b0);
    verificar(2, 8'h01);

    // Abort mid-sweep by reset, then a full clean sweep.
    modo = 0;
    @(negedge clk);
    inicio_a = 1'b1;
    @(negedge clk);
    inicio_a = 1'b0;
    repeat (39) @(negedge clk);
    chk("antes_abort_ocupado", 32'(ocupado_a), 1);
    rst_n = 1'b0;
    #1;
    todo_cero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    barrido(1'b0, 1'b0);
    verificar(0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule

// File: doc/barrido_compuertas.md
# barrido_compuertas

Self-checking sweep engine for the three-input logic-gate selector. On a start pulse it drives the selector's `sel`, `act` and `ent1..ent3` inputs through every function and input combination, and samples `sal`. It assembles an 8-bit truth table per function and compares it against the golden table. It replaces manual stimulus at board level and reports per-function pass/fail to the status registers.

## Interface
- `NUM_FUNC`, default 6: functions swept, `sel` = 1..NUM_FUNC; range 1..7.
- `ESPERA`, default 1: extra settle cycles per combination before sampling `sal_i`; 0 for a combinational DUT.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `inicio`, in, 1: start pulse; ignored while `ocupado`=1.
- `sel_o`, out, 3: function select to DUT.
- `act_o`, out, 1: enable to DUT.
- `ent1_o`, `ent2_o`, `ent3_o`, out, 1 each: data inputs to DUT.
- `sal_i`, in, 1: DUT output.
- `ocupado`, out, 1: sweep in progress.
- `tabla_o`, out, 8: captured truth table; bit k = `sal` for combination k = {ent1,ent2,ent3}, with ent1 as MSB.
- `tabla_valida`, out, 1: one-cycle pulse; `tabla_o` and `sel_o` are valid.
- `fallos_o`, out, 8: bit 0 = disabled-output check failed; bit s = function s mismatched; sticky.
- `listo`, out, 1: one-cycle pulse at sweep end.

## Operation
- Golden tables:
  - sel 1 = AND3 0x80
  - sel 2 = OR3 0xFE
  - sel 3 = NAND3 0x7F
  - sel 4 = NOR3 0x01
  - sel 5 = XOR3 0x96
  - sel 6 = XNOR3 0x69
  - sel 7 = 0x00
- FSM states: REPOSO, DESACT, BARRIDO, REPORTE, FIN.
- REPOSO: all outputs 0. `inicio`=1 -> clear `fallos_o` and `tabla_o`, set `ocupado`, go to DESACT.
- DESACT: `sel_o`=0, `act_o`=0, ent=000, held ESPERA+1 cycles. On the last cycle, `sal_i` must be 0, else set `fallos_o[0]`. Then `sel_o`←1, combination counter k←0, go to BARRIDO.
- BARRIDO: `act_o`=1, ent=k.
  - Each k is held ESPERA+1 cycles. On the last cycle, `tabla_o[k]`←`sal_i`.
  - k=7 sampled -> go to REPORTE; otherwise k←k+1.
- REPORTE (1 cycle): `tabla_valida`=1. If `tabla_o` ≠ golden[`sel_o`], set `fallos_o[sel_o]`.
  - If `sel_o`=NUM_FUNC -> go to FIN.
  - Otherwise `sel_o`+1, k←0, clear `tabla_o`, go to BARRIDO.
- FIN (1 cycle): `listo`=1, `act_o`←0, go to REPOSO.
- `fallos_o` bits above NUM_FUNC stay 0. `tabla_o` and `fallos_o` hold their values in REPOSO until the next `inicio`.

## Timing
- Reset values: every output 0, state REPOSO, k=0.
- Assertion of `rst_n` mid-sweep aborts immediately. Outputs go to 0 with no `listo` pulse.
- Registered Moore outputs throughout.
- `inicio` sampled at edge 0 -> `ocupado`=1 and DESACT drive visible after edge 0.
- Sweep length = (ESPERA+1) + NUM_FUNC·(8·(ESPERA+1)+1) + 1 cycles from the first DESACT cycle to the end of the `listo` cycle. With defaults: 2 + 6·17 + 1 = 105.
- `sal_i` is sampled ESPERA cycles after each combination change. It must be stable within ESPERA+1 edges of the change.
- `inicio` pulses arriving during `ocupado`, including the FIN cycle, are dropped. `inicio` in the cycle after FIN is accepted.
- `inicio` held high continuously restarts the sweep one cycle after each FIN.

## Structure
- Package `compuertas_pkg` holds:
  - the function codes (SEL_AND..SEL_XNOR)
  - the golden table constant array indexed by sel
  - the FSM state enum
- One sub-module, `secuenciador_combinaciones`: k counter with ESPERA hold timer. Outputs: ent vector, sample strobe, last-combination flag.
- The top module holds the FSM, capture, compare and fault registers.

## Test plan
- Correct gate model, defaults -> `tabla_valida` shows 0x80, 0xFE, 0x7F, 0x01, 0x96, 0x69 for sel 1..6. `fallos_o`=0x00. `listo` arrives 105 cycles after the first DESACT cycle.
- Model with XOR wired as OR -> `tabla_o`=0xFE at sel=5, `fallos_o`=0x20, all other tables correct.
- Model driving `sal`=1 while act=0 -> `fallos_o[0]`=1, function bits 0.
- `rst_n` low at cycle 40 -> all outputs 0 asynchronously. A new `inicio` gives a complete correct sweep with `fallos_o`=0x00.
- `inicio` pulsed at cycles 10 and 60 of a running sweep -> ignored, exactly one `listo`. A second sweep started after FIN clears the previous `fallos_o`.
- ESPERA=0, combinational model -> 8·1+1 cycles per function, same tables, total 1+6·9+1 = 56 cycles.
